// File: rtl/y86_pkg.sv
// Shared Y86-64 SEQ definitions: icode constants, status codes, sequencer state, memory-icode test.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEMORY  = 3'd4,
        S_WRBACK  = 3'd5,
        S_PCUPD   = 3'd6,
        S_HALT    = 3'd7
    } seq_state_t;

    // True for instructions that touch data memory (load/store/stack ops).
    function automatic logic is_mem_icode(input logic [3:0] ic);
        case (ic)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: is_mem_icode = 1'b1;
            default:                                      is_mem_icode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting in MEMORY; flags expiry on the MEM_TIMEOUT-th cycle.
// Latency: count is 0 on the first MEMORY cycle; expired is combinational from the count.
// Backpressure: none; saturates at 255 if left running.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [7:0] count;

    // Restart on MEMORY entry, advance while waiting, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/seq_stage_sequencer.sv
// Multi-cycle Y86-64 SEQ controller: strobes F/D/E/M/W/PC stages, owns stat and retired count.
// Latency: 6 busy cycles per instruction minimum (5 with SKIP_NONMEM_STAGE_EN for non-memory icodes).
// Backpressure: stalls in MEMORY until mem_ready or timeout; macro SKIP_NONMEM_STAGE_EN bypasses MEMORY.
module seq_stage_sequencer
    import y86_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
    input  logic             mem_ready,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_en,
    output logic [2:0]       stat,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_t state, state_nxt;
    logic [2:0] stat_nxt;
    logic [3:0] icode_q;
    logic       mem_expired;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state_nxt == S_MEMORY) && (state != S_MEMORY)),
        .run     (state == S_MEMORY),
        .expired (mem_expired)
    );

    // State, status, retired count and the icode captured at DECODE for later routing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            stat        <= STAT_AOK;
            instr_count <= '0;
            icode_q     <= IHALT;
        end else begin
            state <= state_nxt;
            stat  <= stat_nxt;
            if (state == S_DECODE) begin
                icode_q <= icode;
            end
            if ((state == S_PCUPD) && (instr_count != '1)) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Next state and status; faults route to HALT before any PC update.
    always_comb begin
        state_nxt = state;
        stat_nxt  = stat;
        case (state)
            S_IDLE:    if (start) state_nxt = S_FETCH;
            S_FETCH:   state_nxt = S_DECODE;
            S_DECODE: begin
                if (imem_error) begin
                    stat_nxt  = STAT_ADR;
                    state_nxt = S_HALT;
                end else if (!instr_valid) begin
                    stat_nxt  = STAT_INS;
                    state_nxt = S_HALT;
                end else if (icode == IHALT) begin
                    stat_nxt  = STAT_HLT;
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_EXECUTE;
                end
            end
`ifdef SKIP_NONMEM_STAGE_EN
            S_EXECUTE: state_nxt = is_mem_icode(icode_q) ? S_MEMORY : S_WRBACK;
`else
            S_EXECUTE: state_nxt = S_MEMORY;
`endif
            S_MEMORY: begin
                if (!is_mem_icode(icode_q)) begin
                    // Non-memory instruction passing through: no handshake needed.
                    state_nxt = S_WRBACK;
                end else if (mem_ready) begin
                    if (dmem_error) begin
                        stat_nxt  = STAT_ADR;
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_WRBACK;
                    end
                end else if (mem_expired) begin
                    stat_nxt  = STAT_ADR;
                    state_nxt = S_HALT;
                end
            end
            S_WRBACK:  state_nxt = S_PCUPD;
            S_PCUPD:   state_nxt = S_FETCH;
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs: one strobe per active state, busy/halted from state.
    always_comb begin
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        execute_en   = 1'b0;
        memory_en    = 1'b0;
        writeback_en = 1'b0;
        pc_en        = 1'b0;
        case (state)
            S_FETCH:   fetch_en     = 1'b1;
            S_DECODE:  decode_en    = 1'b1;
            S_EXECUTE: execute_en   = 1'b1;
            S_MEMORY:  memory_en    = 1'b1;
            S_WRBACK:  writeback_en = 1'b1;
            S_PCUPD:   pc_en        = 1'b1;
            default:   ;
        endcase
        busy   = (state != S_IDLE) && (state != S_HALT);
        halted = (state == S_HALT);
    end

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// Scoreboard bench for seq_stage_sequencer: expected strobe stream queued, monitor compares each busy cycle.
// Latency: n/a.
// Backpressure: mem_ready driven by directed stimulus.
module tb_seq_stage_sequencer;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, instr_valid, imem_error, dmem_error, mem_ready;
    logic [3:0]  icode;
    logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en;
    logic [2:0]  stat;
    logic        busy, halted;
    logic [31:0] instr_count;

    seq_stage_sequencer #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .icode        (icode),
        .instr_valid  (instr_valid),
        .imem_error   (imem_error),
        .dmem_error   (dmem_error),
        .mem_ready    (mem_ready),
        .fetch_en     (fetch_en),
        .decode_en    (decode_en),
        .execute_en   (execute_en),
        .memory_en    (memory_en),
        .writeback_en (writeback_en),
        .pc_en        (pc_en),
        .stat         (stat),
        .busy         (busy),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] SF = 6'b100000;
    localparam logic [5:0] SD = 6'b010000;
    localparam logic [5:0] SE = 6'b001000;
    localparam logic [5:0] SM = 6'b000100;
    localparam logic [5:0] SW = 6'b000010;
    localparam logic [5:0] SP = 6'b000001;

`ifdef SKIP_NONMEM_STAGE_EN
    localparam int NM = 0;
`else
    localparam int NM = 1;
`endif

    int          n_pass  = 0;
    int          n_total = 0;
    logic        mon_on  = 1'b0;
    logic [5:0]  exp_q[$];
    logic [5:0]  strobes;

    assign strobes = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: every busy cycle consumes one expected strobe vector; idle cycles must be quiet.
    always @(negedge clk) begin
        if (mon_on) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_strobe: got %b expected none", strobes);
                end else begin
                    check("strobe", 64'(strobes), 64'(exp_q.pop_front()));
                end
            end else begin
                check("idle_strobes", 64'(strobes), 64'(0));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_instr(input int mcycles);
        exp_q.push_back(SF);
        exp_q.push_back(SD);
        exp_q.push_back(SE);
        for (int i = 0; i < mcycles; i++) exp_q.push_back(SM);
        exp_q.push_back(SW);
        exp_q.push_back(SP);
    endtask

    // Reset, verify reset state, then launch; returns in the FETCH cycle.
    task automatic start_run(input logic [3:0] ic);
        reset = 1'b1; start = 1'b0; mem_ready = 1'b0; dmem_error = 1'b0;
        imem_error = 1'b0; instr_valid = 1'b1; icode = ic;
        tick(2);
        mon_on = 1'b1;
        check("rst_stat", 64'(stat), 64'(STAT_AOK));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_halted", 64'(halted), 64'(0));
        check("rst_count", 64'(instr_count), 64'(0));
        reset = 1'b0; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Called in PCUPD: next instruction is a halt.
    task automatic finish_halt(input int exp_count);
        icode = IHALT;
        exp_q.push_back(SF);
        exp_q.push_back(SD);
        tick(1);
        check("count_after_pc", 64'(instr_count), 64'(exp_count));
        check("stat_aok", 64'(stat), 64'(STAT_AOK));
        tick(2);
        check("halt_stat", 64'(stat), 64'(STAT_HLT));
        check("halt_halted", 64'(halted), 64'(1));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; icode = IHALT; instr_valid = 1'b0;
        imem_error = 1'b0; dmem_error = 1'b0; mem_ready = 1'b0;

        // T1: OPq, full pass then halt
        push_instr(NM);
        start_run(IOPQ);
        tick(4 + NM);
        check("t1_pc_en", 64'(pc_en), 64'(1));
        finish_halt(1);

        // T6: rrmovq with dmem_error asserted (must be ignored)
        push_instr(NM);
        start_run(IRRMOVQ);
        dmem_error = 1'b1;
        tick(4 + NM);
        check("t6_pc_en", 64'(pc_en), 64'(1));
        dmem_error = 1'b0;
        finish_halt(1);

        // T2: mrmovq, mem_ready on 4th MEMORY cycle
        push_instr(4);
        start_run(IMRMOVQ);
        tick(6);
        mem_ready = 1'b1;
        tick(1);
        mem_ready = 1'b0;
        tick(1);
        check("t2_pc_en", 64'(pc_en), 64'(1));
        finish_halt(1);

        // T3: rmmovq, mem_ready never -> timeout after 15 MEMORY cycles
        exp_q.push_back(SF); exp_q.push_back(SD); exp_q.push_back(SE);
        for (int i = 0; i < 15; i++) exp_q.push_back(SM);
        start_run(IRMMOVQ);
        tick(18);
        check("t3_stat", 64'(stat), 64'(STAT_ADR));
        check("t3_halted", 64'(halted), 64'(1));
        check("t3_count", 64'(instr_count), 64'(0));
        tick(2);
        check("t3_busy", 64'(busy), 64'(0));

        // T8: ret, mem_ready exactly on the timeout cycle wins
        push_instr(15);
        start_run(IRET);
        tick(17);
        mem_ready = 1'b1;
        tick(1);
        mem_ready = 1'b0;
        tick(1);
        check("t8_pc_en", 64'(pc_en), 64'(1));
        finish_halt(1);

        // T7: call, mem_ready with dmem_error -> ADR
        exp_q.push_back(SF); exp_q.push_back(SD); exp_q.push_back(SE); exp_q.push_back(SM);
        start_run(ICALL);
        tick(3);
        mem_ready = 1'b1; dmem_error = 1'b1;
        tick(1);
        mem_ready = 1'b0; dmem_error = 1'b0;
        check("t7_stat", 64'(stat), 64'(STAT_ADR));
        check("t7_count", 64'(instr_count), 64'(0));

        // T4a: imem_error outranks invalid instruction
        exp_q.push_back(SF); exp_q.push_back(SD);
        start_run(IOPQ);
        imem_error = 1'b1; instr_valid = 1'b0;
        tick(2);
        check("t4_adr_prio", 64'(stat), 64'(STAT_ADR));
        imem_error = 1'b0;

        // T4c: invalid instruction -> INS
        exp_q.push_back(SF); exp_q.push_back(SD);
        start_run(IOPQ);
        instr_valid = 1'b0;
        tick(2);
        check("t4_ins", 64'(stat), 64'(STAT_INS));

        // T4b: halt icode, start ignored afterwards
        exp_q.push_back(SF); exp_q.push_back(SD);
        start_run(IHALT);
        tick(2);
        check("t4_hlt", 64'(stat), 64'(STAT_HLT));
        start = 1'b1;
        tick(4);
        check("t4_still_halted", 64'(halted), 64'(1));
        check("t4_stat_frozen", 64'(stat), 64'(STAT_HLT));
        start = 1'b0;

        // T5: reset during MEMORY of the second instruction, then restart
        push_instr(NM);
        start_run(IOPQ);
        tick(4 + NM);
        icode = IMRMOVQ;
        exp_q.push_back(SF); exp_q.push_back(SD); exp_q.push_back(SE);
        exp_q.push_back(SM); exp_q.push_back(SM);
        tick(1);
        check("t5_count_pre", 64'(instr_count), 64'(1));
        tick(4);
        check("t5_in_mem", 64'(memory_en), 64'(1));
        reset = 1'b1;
        tick(1);
        check("t5_rst_busy", 64'(busy), 64'(0));
        check("t5_rst_stat", 64'(stat), 64'(STAT_AOK));
        check("t5_rst_count", 64'(instr_count), 64'(0));
        push_instr(1);
        reset = 1'b0; start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t5_restart_fetch", 64'(fetch_en), 64'(1));
        tick(3);
        mem_ready = 1'b1;
        tick(1);
        mem_ready = 1'b0;
        tick(1);
        check("t5_pc_en", 64'(pc_en), 64'(1));
        finish_halt(1);

        tick(2);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
